// File: rtl/xpb_table_gen.sv
// XPB table writer: streams j*B mod N for j = 0..2**IDX_W-1 as (addr, data) writes.
// Each entry is built from the previous one by a registered add stage followed by a registered conditional-subtract stage.
module xpb_table_gen #(
  parameter int WIDTH = 1024,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] base,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [IDX_W-1:0] wr_addr,
  output logic [WIDTH-1:0] wr_data
);

  typedef enum logic [2:0] {IDLE, CHECK, WRITE, ADD, SUB, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] n_reg, b_reg, acc;
  logic [WIDTH:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             err_reg;
  logic             bad_ops;

  // sum is at most 2N-2, so a single conditional subtract brings it back below N
  function automatic logic [WIDTH-1:0] mod_reduce(input logic [WIDTH:0] s,
                                                  input logic [WIDTH-1:0] m);
    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] d;
    m_ext = {1'b0, m};
    d     = s - m_ext;
    return (s >= m_ext) ? d[WIDTH-1:0] : s[WIDTH-1:0];
  endfunction

  assign bad_ops = (n_reg == '0) || (b_reg >= n_reg);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = bad_ops ? DONE : WRITE;
      WRITE:   if (wr_ready) state_nxt = (idx == LAST_IDX) ? DONE : ADD;
      ADD:     state_nxt = SUB;
      SUB:     state_nxt = WRITE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      acc     <= '0;
      err_reg <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          idx     <= '0;
          acc     <= '0;
          err_reg <= 1'b0;
        end
        CHECK: if (bad_ops) err_reg <= 1'b1;
        WRITE: if (wr_ready && idx != LAST_IDX) idx <= idx + 1'b1;
        SUB:   acc <= mod_reduce(sum, n_reg);
        default: ;
      endcase
    end
  end

  // operand capture and add stage
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      n_reg <= modulus;
      b_reg <= base;
    end
    if (state == ADD) sum <= {1'b0, acc} + {1'b0, b_reg};
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign err      = err_reg;
  assign wr_valid = (state == WRITE);
  assign wr_addr  = idx;
  assign wr_data  = acc;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen at WIDTH=16: table contents, latency, operand errors,
// backpressure stability, and reset/restart behaviour.
module tb_xpb_table_gen;

  localparam int WIDTH = 16;
  localparam int IDX_W = 5;
  localparam int DEPTH = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] modulus = '0;
  logic [WIDTH-1:0] base = '0;
  logic             busy, done, err, wr_valid;
  logic             wr_ready = 1'b1;
  logic [IDX_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int c0 = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  logic done_err = 1'b0;
  bit rand_mode = 1'b0;
  bit prev_stall = 1'b0;
  logic [IDX_W-1:0] prev_addr;
  logic [WIDTH-1:0] prev_data;
  logic [31:0] rec_addr[$];
  logic [31:0] rec_data[$];

  xpb_table_gen #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .modulus(modulus), .base(base),
    .busy(busy), .done(done), .err(err), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    wr_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] xpb_ref(input int j, input int n, input int b);
    longint p;
    p = longint'(j) * longint'(b);
    return 32'(p % longint'(n));
  endfunction

  // Observe half a cycle away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(wr_valid), 32'd1);
        chk("stall_addr", 32'(wr_addr), 32'(prev_addr));
        chk("stall_data", 32'(wr_data), 32'(prev_data));
      end
      if (wr_valid && wr_ready) begin
        rec_addr.push_back(32'(wr_addr));
        rec_data.push_back(32'(wr_data));
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc - c0;
        done_err = err;
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_table(input string tag, input int n, input int b, input int cnt);
    for (int j = 0; j < cnt && j < rec_addr.size(); j++) begin
      chk({tag, "_addr"}, rec_addr[j], 32'(j));
      chk({tag, "_data"}, rec_data[j], xpb_ref(j, n, b));
    end
  endtask

  task automatic run_gen(input string tag, input int n, input int b, input bit exp_err,
                         input bit rnd);
    int k;
    rec_addr.delete();
    rec_data.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    rand_mode = rnd;
    @(posedge clk); #1;
    modulus = WIDTH'(n);
    base    = WIDTH'(b);
    start   = 1'b1;
    c0      = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
    modulus = 16'h0003;
    base    = 16'h0002;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    rand_mode = 1'b0;
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_done_err"}, 32'(done_err), 32'(exp_err));
    chk({tag, "_err_hold"}, 32'(err), 32'(exp_err));
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    if (exp_err) begin
      chk({tag, "_done_cyc"}, 32'(done_cyc), 32'd2);
      chk({tag, "_writes"}, 32'(rec_addr.size()), 32'd0);
    end else begin
      if (rnd) chk({tag, "_done_late"}, 32'(done_cyc >= 96), 32'd1);
      else     chk({tag, "_done_cyc"}, 32'(done_cyc), 32'd96);
      chk({tag, "_writes"}, 32'(rec_addr.size()), 32'(DEPTH));
      check_table(tag, n, b, DEPTH);
    end
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(wr_valid), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);

    run_gen("basic", 'hFFF1, 'h1234, 1'b0, 1'b0);
    if (rec_data.size() > 1) chk("basic_e1", rec_data[1], 32'h1234);

    run_gen("b_eq_n", 'h1000, 'h1000, 1'b1, 1'b0);
    run_gen("n_zero", 0, 'h0005, 1'b1, 1'b0);
    run_gen("after_err", 'hFFF1, 'h1234, 1'b0, 1'b0);

    run_gen("wrap", 'hFFF1, 'hFFF0, 1'b0, 1'b0);
    for (int j = 1; j < DEPTH && j < rec_data.size(); j++)
      chk("wrap_nmj", rec_data[j], 32'('hFFF1 - j));

    run_gen("half", 'h8000, 'h4000, 1'b0, 1'b0);
    if (rec_data.size() > 2) chk("half_e2", rec_data[2], 32'd0);

    run_gen("stall", 'hFFF1, 'h1234, 1'b0, 1'b1);

    // Reset in the middle of a run, with an ignored start pulse beforehand
    rec_addr.delete();
    rec_data.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    modulus = 16'hFFF1;
    base    = 16'h1234;
    start   = 1'b1;
    c0      = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    modulus = 16'h1111;
    base    = 16'h0777;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (rec_addr.size() < 10 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("mid_reached", 32'(rec_addr.size() >= 10), 32'd1);
    check_table("mid", 'hFFF1, 'h1234, 10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(wr_valid), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    chk("mid_still_idle", 32'(busy), 32'd0);

    run_gen("restart", 'hFFF1, 'h1234, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
